cfg_loader: RTL and testbench

- Configuration sequencer for the fabric: accepts bitstream words over a valid/ready stream and shifts them serially into the config chain of one selected tile (clb_tile, mac_tile or sram_tile).
- Pulses that tile's latch strobe when its chain is full.
- Sits at the fpga top level, between the external programming port and the per-tile config chains.
- The cfg_bit data line is shared by all tiles; cfg_en and cfg_latch are one-hot per tile.

---
 rtl/cfg_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_cfg_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
//
// Configuration sequencer for the fabric. Bitstream words arrive on a
// valid/ready stream and are shifted LSB first into the serial config chain of
// one selected tile. Once the tile has received CHAIN_LEN bits, that tile's
// latch strobe is pulsed for one cycle.
//
// Ports:
//   clk        single clock
//   rst        synchronous, active-high reset
//   start      begin loading a tile (only looked at while idle)
//   abort      cancel the load in progress
//   tile_idx   target tile, captured together with start
//   s_data     bitstream word, shifted out LSB first
//   s_valid    s_data valid
//   s_ready    loader accepts a word this cycle
//   cfg_bit    serial config data, shared by every tile
//   cfg_en     one-hot per-tile shift enable
//   cfg_latch  one-hot per-tile single-cycle latch strobe
//   busy       load in progress
//   done       single-cycle pulse when a tile load completes
//   err        single-cycle pulse after a start with an out-of-range tile_idx
// -----------------------------------------------------------------------------
module cfg_loader #(
  parameter  int NUM_TILES = 14,
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 32,
  localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TW-1:0]        tile_idx,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 cfg_bit,
  output logic [NUM_TILES-1:0] cfg_en,
  output logic [NUM_TILES-1:0] cfg_latch,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int WORDS = CHAIN_LEN / WORD_W;
  localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WORD_W-1:0]   sr_r;
  logic [BW-1:0]       bit_cnt_r;
  logic [CW-1:0]       word_cnt_r;
  logic [TW-1:0]       tile_r;
  logic                err_r;

  logic                idx_ok_s;
  logic                last_bit_s;
  logic                last_word_s;
  logic                accept_s;
  logic [NUM_TILES-1:0] tile_oh_s;

  // One-hot decode of a tile number onto the per-tile strobe bus.
  function automatic logic [NUM_TILES-1:0] tile_onehot(input logic [TW-1:0] idx);
    logic [NUM_TILES-1:0] oh;
    oh = {NUM_TILES{1'b0}};
    for (int i = 0; i < NUM_TILES; i++) begin
      if (idx == TW'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Status decodes shared by the next-state logic and the datapath.
  always_comb begin
    // Compare with one extra bit so NUM_TILES itself is representable.
    idx_ok_s    = ({1'b0, tile_idx} < (TW+1)'(NUM_TILES));
    last_bit_s  = (bit_cnt_r == BW'(WORD_W - 1));
    last_word_s = (word_cnt_r == CW'(WORDS - 1));
    // A word is taken only in FETCH and never in a cycle that aborts or resets.
    accept_s    = (state_r == FETCH) && s_valid && !abort && !rst;
    tile_oh_s   = tile_onehot(tile_r);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Abort is honoured in every busy state except LATCH,
  // which leaves on its own after one cycle anyway.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && idx_ok_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (s_valid) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (last_bit_s && last_word_s) begin
          state_nxt_s = LATCH;
        end else if (last_bit_s) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      LATCH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: shift register, bit/word counters, captured tile and err flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r       <= {WORD_W{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      word_cnt_r <= {CW{1'b0}};
      tile_r     <= {TW{1'b0}};
      err_r      <= 1'b0;
    end else begin
      err_r <= (state_r == IDLE) && start && !idx_ok_s;
      case (state_r)
        IDLE: begin
          // tile_idx is captured only here, so a start while busy is ignored.
          if (start && idx_ok_s) begin
            tile_r     <= tile_idx;
            word_cnt_r <= {CW{1'b0}};
          end else begin
            tile_r     <= tile_r;
            word_cnt_r <= word_cnt_r;
          end
        end
        FETCH: begin
          if (accept_s) begin
            sr_r      <= s_data;
            bit_cnt_r <= {BW{1'b0}};
          end else begin
            sr_r      <= sr_r;
            bit_cnt_r <= bit_cnt_r;
          end
        end
        SHIFT: begin
          sr_r <= {1'b0, sr_r[WORD_W-1:1]};
          // Counters stop at their terminal values instead of wrapping.
          if (!last_bit_s) begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end else if (!last_word_s && !abort) begin
            word_cnt_r <= word_cnt_r + CW'(1);
          end else begin
            bit_cnt_r  <= bit_cnt_r;
            word_cnt_r <= word_cnt_r;
          end
        end
        LATCH: begin
          sr_r <= sr_r;
        end
        default: begin
          sr_r <= sr_r;
        end
      endcase
    end
  end

  // Output decode from registered state; s_ready alone also sees abort/rst so
  // that a word offered in a cancelling cycle is visibly refused.
  always_comb begin
    busy      = (state_r != IDLE);
    done      = (state_r == LATCH);
    err       = err_r;
    s_ready   = (state_r == FETCH) && !abort && !rst;
    if (state_r == SHIFT) begin
      cfg_bit = sr_r[0];
      cfg_en  = tile_oh_s;
    end else begin
      cfg_bit = 1'b0;
      cfg_en  = {NUM_TILES{1'b0}};
    end
    if (state_r == LATCH) begin
      cfg_latch = tile_oh_s;
    end else begin
      cfg_latch = {NUM_TILES{1'b0}};
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: directed loads compared cycle by cycle
// against a timeline of expected outputs built from the stimulus parameters.
module tb_cfg_loader;

  localparam int NT = 14;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [TW-1:0] tile_idx;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          cfg_bit;
  logic [NT-1:0] cfg_en;
  logic [NT-1:0] cfg_latch;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  cfg_loader #(.NUM_TILES(14), .CHAIN_LEN(64), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tile_idx(tile_idx),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .cfg_bit(cfg_bit),
    .cfg_en(cfg_en), .cfg_latch(cfg_latch), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Layout: {s_ready, cfg_bit, busy, done, err, cfg_en[13:0], cfg_latch[13:0]}
  function automatic logic [63:0] observed();
    return {31'd0, s_ready, cfg_bit, busy, done, err, cfg_en, cfg_latch};
  endfunction

  // Expected outputs in cycle c of a load (start in cycle 0) on `tile`,
  // with `st` cycles of s_valid low at the start of each fetch.
  function automatic logic [63:0] expected(input int c, input int tile,
                                           input logic [31:0] w0, input logic [31:0] w1,
                                           input int st, input int ab_c);
    logic fetch, sh0, sh1, lat, bz, cb;
    logic [NT-1:0] oh, en, lt;
    oh    = 14'd1 << tile;
    fetch = (c >= 1 && c <= 1 + st) || (c >= 34 + st && c <= 34 + 2*st);
    sh0   = (c >= 2 + st && c <= 33 + st);
    sh1   = (c >= 35 + 2*st && c <= 66 + 2*st);
    lat   = (c == 67 + 2*st);
    bz    = (c >= 1 && c <= 67 + 2*st);
    cb    = 1'b0;
    if (sh0) cb = w0[c - 2 - st];
    if (sh1) cb = w1[c - 35 - 2*st];
    en    = (sh0 || sh1) ? oh : 14'd0;
    lt    = lat ? oh : 14'd0;
    if (c == ab_c) fetch = 1'b0;
    return {31'd0, fetch, cb, bz, lat, 1'b0, en, lt};
  endfunction

  // Run one load. ab_c / rs_c / nz_c (-1 = unused) place an abort, a reset or
  // a spurious start(tile 0) in that cycle.
  task automatic run_load(input string tag, input int tile,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int st, input int ab_c, input int rs_c, input int nz_c);
    int last_c;
    logic [63:0] e;
    if (ab_c >= 0)      last_c = ab_c + 4;
    else if (rs_c >= 0) last_c = rs_c + 6;
    else                last_c = 69 + 2*st;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      start    = (c == 0) || (c == nz_c);
      tile_idx = (c == nz_c) ? 4'd0 : 4'(tile);
      abort    = (c == ab_c);
      rst      = (c == rs_c);
      s_valid  = !((c >= 1 && c <= st) || (c >= 34 + st && c <= 33 + 2*st));
      s_data   = (c <= 1 + st) ? w0 : w1;
      @(negedge clk);
      e = expected(c, tile, w0, w1, st, ab_c);
      if ((ab_c >= 0 && c > ab_c) || (rs_c >= 0 && c > rs_c)) e = 64'd0;
      if (c != rs_c) check($sformatf("%s c%0d", tag, c), observed(), e);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; rst = 1'b0; s_valid = 1'b0; s_data = 32'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tile_idx = 4'd0;
    s_data = 32'd0; s_valid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", observed(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", observed(), 64'd0);

    // Nominal load on the mac tile.
    run_load("nominal", 12, 32'hA5A5_0001, 32'h8000_FFFF, 0, -1, -1, -1);

    // Backpressure: 5 stall cycles in each fetch, 78 cycles in total.
    run_load("bp", 7, 32'h1234_5678, 32'hDEAD_BEEF, 5, -1, -1, -1);

    // Illegal tile index, then a legal load.
    @(posedge clk); #1;
    start = 1'b1; tile_idx = 4'd14;
    @(negedge clk);
    check("illegal c0", observed(), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; tile_idx = 4'd0;
    @(negedge clk);
    check("illegal c1", observed(), 64'd1 << 28);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal c2", observed(), 64'd0);
    run_load("after_illegal", 0, 32'hFFFF_0000, 32'h0000_FFFF, 0, -1, -1, -1);

    // Abort while shifting word1, then a restart on tile 3.
    run_load("abort_shift", 12, 32'hA5A5_0001, 32'h8000_FFFF, 0, 40, -1, -1);
    run_load("restart", 3, 32'hCAFE_F00D, 32'h0F0F_3C3C, 0, -1, -1, -1);

    // Abort in fetch while a word is offered: it must be refused.
    run_load("abort_fetch", 2, 32'h0000_0003, 32'hFFFF_FFFF, 0, 34, -1, -1);

    // Reset while fetching word1.
    run_load("rst_fetch", 9, 32'h5555_AAAA, 32'h7777_1111, 0, -1, 34, -1);

    // Spurious start(tile 0) during a load on tile 5.
    run_load("start_busy", 5, 32'h0123_4567, 32'h89AB_CDEF, 0, -1, -1, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
